// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit arbiter: FSM state type, the
// polarity of the UART Tx ready/busy line, and default block parameters.
// No ports (package).
// -----------------------------------------------------------------------------
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      BUSY = 2'd2
   } arb_state_t;

   // UART Tx ready/busy line levels
   localparam logic TX_READY = 1'b1;
   localparam logic TX_BUSY  = 1'b0;

   localparam int WORD_LENGTH_DEF = 8;
   localparam int NUM_REQ_DEF     = 4;
   localparam int TIMEOUT_DEF     = 1023;

endpackage : uart_pkg

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker: returns the first set request bit at or
// after rr_ptr_i, scanning upward and wrapping at NUM_REQ.
// Ports:
//   req_i      per-requester request vector
//   rr_ptr_i   highest-priority index (must be < NUM_REQ)
//   win_vld_o  at least one request is set
//   win_idx_o  index of the winning requester
// -----------------------------------------------------------------------------
module rr_pick import uart_pkg::*; #(
   parameter int NUM_REQ = NUM_REQ_DEF,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IDX_W-1:0]   rr_ptr_i,
   output logic               win_vld_o,
   output logic [IDX_W-1:0]   win_idx_o
);

   localparam int             SUM_W     = IDX_W + 1;
   localparam logic [IDX_W:0] NUM_REQ_W = SUM_W'(NUM_REQ);

   logic [IDX_W:0]   sum_s;
   logic [IDX_W-1:0] cand_s;

   // Scan offsets from farthest to nearest so the nearest set bit is the last
   // one written; the wrap is an explicit subtract so odd NUM_REQ works.
   always_comb begin
      win_vld_o = 1'b0;
      win_idx_o = '0;
      sum_s     = '0;
      cand_s    = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         sum_s  = {1'b0, rr_ptr_i} + SUM_W'(k);
         cand_s = (sum_s >= NUM_REQ_W) ? IDX_W'(sum_s - NUM_REQ_W) : IDX_W'(sum_s);
         if (req_i[cand_s]) begin
            win_vld_o = 1'b1;
            win_idx_o = cand_s;
         end else begin
            win_vld_o = win_vld_o;
            win_idx_o = win_idx_o;
         end
      end
   end

endmodule : rr_pick

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
// Round-robin scheduler sharing one UART transmitter among NUM_REQ byte
// requesters. The winner's byte is latched and held for the whole frame; the
// winner is acked when the transmitter goes busy; a watchdog aborts grants the
// transmitter never accepts.
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   arb_en_i              allow new grants (in-flight frame always completes)
//   req_i, req_data_i     level requests and packed bytes (i at [i*WL +: WL])
//   ack_o                 one-cycle pulse to the winner on acceptance
//   done_o                one-cycle pulse when the frame finishes
//   timeout_err_o         one-cycle pulse on watchdog abort
//   grant_vld_o           a grant is in flight
//   grant_idx_o           current or last granted index
//   uart_tx_rqst_o        request to the UART Tx
//   uart_tx_data_o        byte to the UART Tx
//   uart_ready_i          UART Tx ready (1) / busy (0)
// -----------------------------------------------------------------------------
module uart_tx_arbiter import uart_pkg::*; #(
   parameter int NUM_REQ     = NUM_REQ_DEF,
   parameter int WORD_LENGTH = WORD_LENGTH_DEF,
   parameter int TIMEOUT     = TIMEOUT_DEF,
   parameter int IDX_W       = $clog2(NUM_REQ)
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic                           arb_en_i,
   input  logic [NUM_REQ-1:0]             req_i,
   input  logic [NUM_REQ*WORD_LENGTH-1:0] req_data_i,
   output logic [NUM_REQ-1:0]             ack_o,
   output logic                           done_o,
   output logic                           timeout_err_o,
   output logic                           grant_vld_o,
   output logic [IDX_W-1:0]               grant_idx_o,
   output logic                           uart_tx_rqst_o,
   output logic [WORD_LENGTH-1:0]         uart_tx_data_o,
   input  logic                           uart_ready_i
);

   localparam int                  WDOG_W    = $clog2(TIMEOUT + 1);
   localparam logic [WDOG_W-1:0]   WDOG_LAST = WDOG_W'(TIMEOUT - 1);
   localparam logic [WDOG_W-1:0]   WDOG_MAX  = {WDOG_W{1'b1}};
   localparam logic [NUM_REQ-1:0]  ACK_ONE   = {{(NUM_REQ-1){1'b0}}, 1'b1};
   localparam logic [IDX_W-1:0]    IDX_LAST  = IDX_W'(NUM_REQ - 1);

   arb_state_t             state_q, state_d;
   logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0]       grant_idx_q, grant_idx_d;
   logic [WORD_LENGTH-1:0] data_q, data_d;
   logic                   rqst_q, rqst_d;
   logic [NUM_REQ-1:0]     ack_q, ack_d;
   logic                   done_q, done_d;
   logic                   tmo_q, tmo_d;
   logic                   gvld_q, gvld_d;
   logic [WDOG_W-1:0]      wdog_q, wdog_d;
   logic                   ready_seen_q, ready_seen_d;

   logic                   win_vld_s;
   logic [IDX_W-1:0]       win_idx_s;
   logic [WORD_LENGTH-1:0] win_data_s;

   // Next round-robin pointer: one past the last grant, wrapped explicitly.
   function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] idx);
      if (idx == IDX_LAST) begin
         return '0;
      end else begin
         return idx + 1'b1;
      end
   endfunction

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr_pick (
      .req_i     (req_i),
      .rr_ptr_i  (rr_ptr_q),
      .win_vld_o (win_vld_s),
      .win_idx_o (win_idx_s)
   );

   // Select the winner's byte from the packed request data.
   always_comb begin
      win_data_s = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (win_idx_s == IDX_W'(i)) begin
            win_data_s = req_data_i[i*WORD_LENGTH +: WORD_LENGTH];
         end else begin
            win_data_s = win_data_s;
         end
      end
   end

   // FSM next state, watchdog, data latch and pulse outputs.
   always_comb begin
      state_d      = state_q;
      rr_ptr_d     = rr_ptr_q;
      grant_idx_d  = grant_idx_q;
      data_d       = data_q;
      rqst_d       = rqst_q;
      wdog_d       = wdog_q;
      ack_d        = '0;
      done_d       = 1'b0;
      tmo_d        = 1'b0;
      // After reset the frame the UART may still be sending is unknown, so
      // no grant is issued until the transmitter has been seen ready once.
      ready_seen_d = ready_seen_q | (uart_ready_i == TX_READY);

      case (state_q)
         IDLE: begin
            if (arb_en_i && win_vld_s && (ready_seen_q || (uart_ready_i == TX_READY))) begin
               state_d     = REQ;
               grant_idx_d = win_idx_s;
               data_d      = win_data_s;
               rqst_d      = 1'b1;
               wdog_d      = '0;
            end else begin
               state_d = IDLE;
            end
         end
         REQ: begin
            // Acceptance has priority over the watchdog on the same cycle.
            if (uart_ready_i == TX_BUSY) begin
               state_d = BUSY;
               rqst_d  = 1'b0;
               ack_d   = ACK_ONE << grant_idx_q;
            end else if (wdog_q == WDOG_LAST) begin
               state_d  = IDLE;
               rqst_d   = 1'b0;
               tmo_d    = 1'b1;
               rr_ptr_d = next_ptr(grant_idx_q);
            end else begin
               wdog_d = (wdog_q == WDOG_MAX) ? wdog_q : wdog_q + 1'b1;
            end
         end
         BUSY: begin
            if (uart_ready_i == TX_READY) begin
               state_d  = IDLE;
               done_d   = 1'b1;
               rr_ptr_d = next_ptr(grant_idx_q);
            end else begin
               state_d = BUSY;
            end
         end
         default: begin
            state_d = IDLE;
            rqst_d  = 1'b0;
         end
      endcase

      gvld_d = (state_d != IDLE);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         rr_ptr_q     <= '0;
         grant_idx_q  <= '0;
         data_q       <= '0;
         rqst_q       <= 1'b0;
         ack_q        <= '0;
         done_q       <= 1'b0;
         tmo_q        <= 1'b0;
         gvld_q       <= 1'b0;
         wdog_q       <= '0;
         ready_seen_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         rr_ptr_q     <= rr_ptr_d;
         grant_idx_q  <= grant_idx_d;
         data_q       <= data_d;
         rqst_q       <= rqst_d;
         ack_q        <= ack_d;
         done_q       <= done_d;
         tmo_q        <= tmo_d;
         gvld_q       <= gvld_d;
         wdog_q       <= wdog_d;
         ready_seen_q <= ready_seen_d;
      end
   end

   assign ack_o          = ack_q;
   assign done_o         = done_q;
   assign timeout_err_o  = tmo_q;
   assign grant_vld_o    = gvld_q;
   assign grant_idx_o    = grant_idx_q;
   assign uart_tx_rqst_o = rqst_q;
   assign uart_tx_data_o = data_q;

endmodule : uart_tx_arbiter

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Self-checking bench: table of directed frames, hand-written corner-case
// sequences (fairness, watchdog, arb_en low, reset mid-REQ), then randomized
// traffic compared cycle by cycle with a behavioural reference model.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

   localparam int N   = 4;
   localparam int WL  = 8;
   localparam int TMO = 16;

   logic            clk = 1'b0;
   logic            rst;
   logic            arb_en;
   logic [N-1:0]    req;
   logic [N*WL-1:0] req_data;
   logic            uart_ready;
   logic [N-1:0]    ack_o;
   logic            done_o;
   logic            timeout_err_o;
   logic            grant_vld_o;
   logic [1:0]      grant_idx_o;
   logic            uart_tx_rqst_o;
   logic [WL-1:0]   uart_tx_data_o;

   int n_pass  = 0;
   int n_total = 0;
   int ack_cnt [N];

   uart_tx_arbiter #(
      .NUM_REQ     (N),
      .WORD_LENGTH (WL),
      .TIMEOUT     (TMO)
   ) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .arb_en_i       (arb_en),
      .req_i          (req),
      .req_data_i     (req_data),
      .ack_o          (ack_o),
      .done_o         (done_o),
      .timeout_err_o  (timeout_err_o),
      .grant_vld_o    (grant_vld_o),
      .grant_idx_o    (grant_idx_o),
      .uart_tx_rqst_o (uart_tx_rqst_o),
      .uart_tx_data_o (uart_tx_data_o),
      .uart_ready_i   (uart_ready)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation did not finish, expected finish before 1ms");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] outs();
      return {14'd0, ack_o, done_o, timeout_err_o, grant_vld_o, grant_idx_o,
              uart_tx_rqst_o, uart_tx_data_o};
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   // One complete frame: grant, accept after acc_dly, busy for busy_len.
   // drop_mode: 0 keep req, 1 drop winner's req, 2 drop all and scramble data.
   task automatic do_frame(input string tag, input logic [1:0] exp_idx, input logic [7:0] exp_data,
                           input int acc_dly, input int busy_len, input int drop_mode);
      int         n;
      logic [3:0] ack_exp;
      n       = 0;
      ack_exp = 4'b0001 << exp_idx;
      while (uart_tx_rqst_o !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      chk({tag, "_latency"}, n, 1);
      chk({tag, "_idx"}, grant_idx_o, exp_idx);
      chk({tag, "_data"}, uart_tx_data_o, exp_data);
      chk({tag, "_grant_flags"}, {grant_vld_o, done_o, timeout_err_o, ack_o}, {1'b1, 1'b0, 1'b0, 4'b0});
      for (int j = 1; j < acc_dly; j++) begin
         tick();
         chk({tag, "_rqst_hold"}, {uart_tx_rqst_o, ack_o}, {1'b1, 4'b0});
      end
      uart_ready = 1'b0;
      tick();
      chk({tag, "_ack"}, {uart_tx_rqst_o, ack_o}, {1'b0, ack_exp});
      for (int i = 0; i < N; i++) begin
         if (ack_o[i]) ack_cnt[i]++;
      end
      if (drop_mode == 1) begin
         req[exp_idx] = 1'b0;
      end else if (drop_mode == 2) begin
         req      = '0;
         req_data = ~req_data;
      end
      for (int j = 1; j < busy_len; j++) begin
         tick();
         chk({tag, "_busy"}, {ack_o, done_o, uart_tx_data_o, grant_vld_o, uart_tx_rqst_o},
             {4'b0, 1'b0, exp_data, 1'b1, 1'b0});
      end
      uart_ready = 1'b1;
      tick();
      chk({tag, "_done"}, {done_o, grant_vld_o, ack_o, uart_tx_data_o, grant_idx_o},
          {1'b1, 1'b0, 4'b0, exp_data, exp_idx});
   endtask

   // ---------------- behavioural reference model -------------------------
   bit         m_active;
   bit         m_sent;
   bit         m_seen;
   int         m_ptr;
   int         m_wait;
   logic [1:0] m_idx;
   logic [7:0] m_data;
   logic [3:0] m_ack;
   bit         m_done;
   bit         m_tmo;

   function automatic int mpick(input logic [N-1:0] r, input int p);
      for (int d = 0; d < N; d++) begin
         if (r[(p + d) % N]) return (p + d) % N;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_active = 1'b0; m_sent = 1'b0; m_seen = 1'b0;
      m_ptr = 0; m_wait = 0; m_idx = 2'd0; m_data = 8'd0;
      m_ack = 4'd0; m_done = 1'b0; m_tmo = 1'b0;
   endtask

   // Predict the outputs produced by the coming clock edge.
   task automatic model_step();
      int w;
      m_ack  = 4'd0;
      m_done = 1'b0;
      m_tmo  = 1'b0;
      if (!m_active) begin
         w = mpick(req, m_ptr);
         if (arb_en && w >= 0 && (m_seen || uart_ready)) begin
            m_active = 1'b1;
            m_sent   = 1'b0;
            m_idx    = 2'(w);
            m_data   = req_data[w*WL +: WL];
            m_wait   = 0;
         end
      end else if (!m_sent) begin
         if (!uart_ready) begin
            m_sent = 1'b1;
            m_ack  = 4'b0001 << m_idx;
         end else if (m_wait == TMO - 1) begin
            m_active = 1'b0;
            m_tmo    = 1'b1;
            m_ptr    = (int'(m_idx) + 1) % N;
         end else begin
            m_wait++;
         end
      end else if (uart_ready) begin
         m_active = 1'b0;
         m_done   = 1'b1;
         m_ptr    = (int'(m_idx) + 1) % N;
      end
      if (uart_ready) m_seen = 1'b1;
   endtask

   function automatic logic [31:0] model_outs();
      return {14'd0, m_ack, m_done, m_tmo, m_active, m_idx, (m_active && !m_sent), m_data};
   endfunction

   // ---------------- directed vector table --------------------------------
   typedef struct {
      logic [3:0]  req;
      logic [31:0] data;
      logic [1:0]  exp_idx;
      logic [7:0]  exp_data;
      int          acc_dly;
      int          busy_len;
   } vec_t;

   vec_t tbl [10];

   initial begin
      int         cnt;
      int         u_cnt;
      bit         u_busy;
      logic [31:0] fd;

      tbl[0] = '{4'b0100, 32'h11A52233, 2'd2, 8'hA5, 3, 100};
      tbl[1] = '{4'b0101, 32'h40302010, 2'd0, 8'h10, 1, 2};
      tbl[2] = '{4'b0101, 32'h41312111, 2'd2, 8'h31, 2, 1};
      tbl[3] = '{4'b1111, 32'h43332313, 2'd3, 8'h43, 1, 1};
      tbl[4] = '{4'b1111, 32'h44342414, 2'd0, 8'h14, 4, 3};
      tbl[5] = '{4'b1000, 32'h45352515, 2'd3, 8'h45, 1, 2};
      tbl[6] = '{4'b0110, 32'h46362616, 2'd1, 8'h26, 2, 2};
      tbl[7] = '{4'b0010, 32'h47372717, 2'd1, 8'h27, 1, 1};
      tbl[8] = '{4'b1001, 32'h48382818, 2'd3, 8'h48, 5, 4};
      tbl[9] = '{4'b1111, 32'h49392919, 2'd0, 8'h19, 1, 1};

      rst        = 1'b1;
      arb_en     = 1'b0;
      req        = '0;
      req_data   = '0;
      uart_ready = 1'b1;
      for (int i = 0; i < N; i++) ack_cnt[i] = 0;

      // Reset values
      tick();
      tick();
      chk("reset_outputs", outs(), 32'd0);
      rst    = 1'b0;
      arb_en = 1'b1;

      // Table-driven frames (rr pointer progression starting from 0)
      for (int v = 0; v < 10; v++) begin
         req      = tbl[v].req;
         req_data = tbl[v].data;
         do_frame($sformatf("tbl%0d", v), tbl[v].exp_idx, tbl[v].exp_data,
                  tbl[v].acc_dly, tbl[v].busy_len, 2);
      end

      // Fairness: all requesters held for 8 frames
      do_reset();
      for (int i = 0; i < N; i++) ack_cnt[i] = 0;
      fd       = 32'hD3C2B1A0;
      req      = 4'b1111;
      req_data = fd;
      for (int f = 0; f < 8; f++) begin
         do_frame($sformatf("fair%0d", f), 2'(f % N), fd[(f % N)*8 +: 8], 1, 2, (f == 7) ? 2 : 0);
      end
      for (int i = 0; i < N; i++) chk($sformatf("fair_ackcnt%0d", i), ack_cnt[i], 2);

      // Watchdog: transmitter never accepts
      do_reset();
      req      = 4'b0011;
      req_data = 32'h00002211;
      cnt      = 0;
      while (uart_tx_rqst_o !== 1'b1 && cnt < 20) begin
         tick();
         cnt++;
      end
      chk("wd_grant", {uart_tx_rqst_o, grant_idx_o}, {1'b1, 2'd0});
      cnt = 0;
      while (uart_tx_rqst_o === 1'b1 && cnt < 40) begin
         cnt++;
         tick();
         chk("wd_no_ack", ack_o, 4'd0);
      end
      chk("wd_rqst_cycles", cnt, TMO);
      chk("wd_timeout_pulse", {timeout_err_o, grant_vld_o, done_o}, {1'b1, 1'b0, 1'b0});
      do_frame("wd_regrant", 2'd1, 8'h22, 2, 3, 2);
      chk("wd_pulse_cleared", timeout_err_o, 1'b0);

      // arb_en low mid-BUSY, then reset mid-REQ
      do_reset();
      req      = 4'b0001;
      req_data = 32'h00000044;
      tick();
      chk("en_grant", {uart_tx_rqst_o, grant_idx_o, uart_tx_data_o}, {1'b1, 2'd0, 8'h44});
      uart_ready = 1'b0;
      tick();
      chk("en_ack", ack_o, 4'b0001);
      req    = 4'b1111;
      arb_en = 1'b0;
      repeat (3) tick();
      uart_ready = 1'b1;
      tick();
      chk("en_done", {done_o, grant_vld_o}, {1'b1, 1'b0});
      for (int j = 0; j < 8; j++) begin
         tick();
         chk("en_no_grant", {uart_tx_rqst_o, grant_vld_o}, 2'b00);
      end
      arb_en = 1'b1;
      tick();
      chk("en_regrant", {uart_tx_rqst_o, grant_idx_o}, {1'b1, 2'd1});
      rst        = 1'b1;
      uart_ready = 1'b0;
      tick();
      chk("rst_mid_req", outs(), 32'd0);
      rst = 1'b0;
      for (int j = 0; j < 4; j++) begin
         tick();
         chk("rst_wait_ready", {uart_tx_rqst_o, grant_vld_o}, 2'b00);
      end
      uart_ready = 1'b1;
      tick();
      chk("rst_first_grant", {uart_tx_rqst_o, grant_idx_o}, {1'b1, 2'd0});
      uart_ready = 1'b0;
      tick();
      chk("rst_ack", ack_o, 4'b0001);
      req        = '0;
      uart_ready = 1'b1;
      tick();
      chk("rst_done", done_o, 1'b1);

      // Randomized traffic against the reference model
      do_reset();
      model_reset();
      req        = '0;
      arb_en     = 1'b1;
      uart_ready = 1'b1;
      u_busy     = 1'b0;
      u_cnt      = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         model_step();
         tick();
         chk($sformatf("rand_cyc%0d", cyc), outs(), model_outs());
         // requesters hold until acked; bytes churn every cycle
         for (int i = 0; i < N; i++) begin
            if (ack_o[i]) begin
               req[i] = 1'b0;
            end else if (!req[i] && $urandom_range(0, 3) == 0) begin
               req[i] = 1'b1;
            end
         end
         req_data = $urandom;
         arb_en   = ($urandom_range(0, 9) != 0);
         // UART model: accept after 0..19 cycles, stay busy 1..8 cycles
         if (u_busy) begin
            if (u_cnt == 0) begin
               uart_ready = 1'b1;
               u_busy     = 1'b0;
            end else begin
               u_cnt--;
            end
         end else if (uart_tx_rqst_o) begin
            if (u_cnt == 0) begin
               uart_ready = 1'b0;
               u_busy     = 1'b1;
               u_cnt      = $urandom_range(0, 7);
            end else begin
               u_cnt--;
            end
         end else begin
            u_cnt = $urandom_range(0, 19);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule : tb_uart_tx_arbiter

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin scheduler that shares one UART transmitter among NUM_REQ byte requesters. It sits between the APB-side requesters and the UART Tx request/data/ready-busy handshake. It latches the winning requester's byte and holds it stable for the whole frame. It acknowledges the winner once the transmitter goes busy, and frees the transmitter after the frame completes. A watchdog aborts grants the transmitter never accepts.

## Interface
- NUM_REQ, 4: number of requesters; range 2..8.
- WORD_LENGTH, `WORD_LENGTH (8): data width per requester.
- TIMEOUT, 1023: maximum cycles in REQ state before abort; minimum 2.
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- arb_en  in  1  1 = new grants allowed; 0 = no new grant, an in-flight frame completes.
- req  in  NUM_REQ  per-requester level request; must be held until ack.
- req_data  in  NUM_REQ*WORD_LENGTH  packed bytes; requester i owns bits [i*WORD_LENGTH +: WORD_LENGTH].
- ack  out  NUM_REQ  one-cycle pulse to the winner when its byte is accepted.
- done  out  1  one-cycle pulse when the granted frame finishes.
- timeout_err  out  1  one-cycle pulse on watchdog abort.
- grant_vld  out  1  a grant is in flight (state != IDLE).
- grant_idx  out  $clog2(NUM_REQ)  index of the current or last grant.
- uart_tx_rqst  out  1  request to the UART Tx.
- uart_tx_data  out  WORD_LENGTH  byte to the UART Tx; stable from REQ entry until return to IDLE.
- uart_ready  in  1  UART Tx ready/busy; `Tx_READY = 1 means ready, `Tx_BUSY = 0 means busy.

## Operation
- FSM states: IDLE, REQ, BUSY.
- IDLE, when arb_en=1 and req!=0:
  - Winner = first set req bit at or after rr_ptr, scanning upward with wrap.
  - Latch grant_idx, uart_tx_data <= winner's byte, uart_tx_rqst <= 1, clear wdog, go to REQ.
- REQ, when uart_ready==0 (transmitter accepted):
  - uart_tx_rqst <= 0, ack[grant_idx] <= 1, go to BUSY.
- REQ, else if wdog==TIMEOUT-1:
  - uart_tx_rqst <= 0, timeout_err <= 1, rr_ptr <= grant_idx+1 (mod NUM_REQ), go to IDLE.
  - No ack is issued; the requester may retry.
- REQ, otherwise: wdog increments.
- BUSY, when uart_ready==1: done <= 1, rr_ptr <= grant_idx+1 (mod NUM_REQ), go to IDLE.
- rr_ptr wraps at NUM_REQ. Non-power-of-2 NUM_REQ must wrap explicitly, never by overflow.
- A requester dropping req after the grant has no effect; the latched byte is still sent.
- req changes while not in IDLE are ignored.
- arb_en going low mid-grant does not abort the grant.
- wdog width is $clog2(TIMEOUT+1) and it saturates; it never wraps.

## Timing
- Reset values:
  - Outputs: ack, done, timeout_err, grant_vld, uart_tx_rqst = 0; grant_idx = 0; uart_tx_data = 0.
  - Internal: rr_ptr = 0; state = IDLE.
- All outputs are registered.
- Grant latency: req sampled in IDLE at edge N → uart_tx_rqst=1 and grant_vld=1 after edge N.
- Ack latency: uart_ready sampled 0 at edge M → ack high for exactly the cycle after M; uart_tx_rqst low from the same edge.
- Done latency: uart_ready sampled 1 in BUSY at edge K → done high for the cycle after K, state IDLE.
- Earliest regrant: at edge K+1, giving 2 cycles between consecutive uart_tx_rqst assertions.
- Back-to-back grants never skip IDLE.
- Reset mid-frame: all state and outputs return to reset values on the next edge. The UART frame in progress is not tracked; after reset, the first grant waits for uart_ready==1 before asserting uart_tx_rqst.
- Simultaneous events in REQ: uart_ready==0 on the timeout cycle counts as accepted; ack wins and there is no timeout_err.

## Structure
- Shared package (uart_pkg, alongside globals.vh):
  - arb_state_t enum {IDLE, REQ, BUSY}.
  - `Tx_READY and `Tx_BUSY constants.
  - Default NUM_REQ and TIMEOUT.
- Sub-module rr_pick: combinational round-robin picker.
  - Inputs: req, rr_ptr.
  - Outputs: win_vld, win_idx.
  - Instantiated once.
- Everything else (FSM, wdog, data latch, pulse regs) lives in uart_tx_arbiter.

## Test plan
- Single requester: req=4'b0100, byte 8'hA5; UART model drops ready 3 cycles after request and raises it 100 cycles later.
  - Expect grant_idx=2 and uart_tx_data=8'hA5 throughout.
  - Expect ack[2] 1 cycle after ready falls, done 1 cycle after ready rises.
- Fairness: req=4'b1111 held for 8 frames.
  - Expect grant order 0,1,2,3,0,1,2,3, each requester acked exactly twice.
- Wrap/skip: rr_ptr=3, req=4'b0101.
  - Expect grant 0, then 2.
- Watchdog: TIMEOUT=16, uart_ready held 1.
  - Expect uart_tx_rqst high exactly 16 cycles, timeout_err pulse, no ack, then regrant of the next requester.
- arb_en=0 mid-BUSY, then reset mid-REQ.
  - Expect the current frame's done and no new grant while arb_en=0.
  - After rst, expect all outputs 0 the next cycle and rr_ptr=0.
